// File: rtl/alu_pkg.sv
// Shared constants, the stage-1 control bundle and a sign-extension helper
// for the pipelined add/subtract unit.
package alu_pkg;

    localparam logic ADDSUB_ADD = 1'b1;
    localparam logic ADDSUB_SUB = 1'b0;

    // Widest value sext_to can produce; callers size-cast down to their target width.
    localparam int SEXT_MAX = 128;

    typedef struct packed {
        logic valid;
        logic addsub;
        logic acc_mode;
        logic acc_clr;
    } ctrl_t;

    function automatic logic [SEXT_MAX-1:0] sext_to(input logic [SEXT_MAX-1:0] val,
                                                    input int src_w);
        logic [SEXT_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < SEXT_MAX; i++) begin
            r[i] = (i < src_w) ? val[i] : val[src_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_pipe_dly.sv
// Valid-qualified delay line with clock enable and synchronous reset.
// DEPTH = 0 is a pure pass-through.
module alu_pipe_dly #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, rst, ce};
            assign out_valid  = in_valid;
            assign out_data   = in_data;
        end else begin : g_dly
            logic [DEPTH-1:0] valid_q;
            logic [WIDTH-1:0] data_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= '0;
                    // NOTE: data stages are reset too because c must read 0 after reset;
                    // with a FIFO-sized memory this reset would normally be dropped.
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else if (ce) begin
                    valid_q[0] <= in_valid;
                    if (in_valid) data_q[0] <= in_data;
                    // Data only moves with a valid so the output holds its last result.
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined signed add/subtract with valid, ce stall and running accumulator.
// Define ALU_ADDSUB_PIPE_SAT_EN to saturate accumulator overflow instead of wrapping.
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH       = 36,
    parameter int OUT_WIDTH   = 55,   // must be >= WIDTH+1
    parameter int PIPE_STAGES = 2     // 2..6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 addsub,
    input  logic                 acc_mode,
    input  logic                 acc_clr,
    output logic [OUT_WIDTH-1:0] c,
    output logic                 out_valid,
    output logic                 ovf
);

    localparam int MSB = OUT_WIDTH - 1;
    localparam logic [OUT_WIDTH-1:0] SAT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] a_q, b_q;
    ctrl_t            ctrl_q;

    // Stage 1: operands and control; only acc_clr survives an invalid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            ctrl_q <= '0;
        end else if (ce) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            a_q    <= a;
            b_q    <= b;
            ctrl_q <= '{valid:    in_valid,
                        addsub:   in_valid & addsub,
                        acc_mode: in_valid & acc_mode,
                        acc_clr:  acc_clr};
        end
    end

    logic [WIDTH:0]     a_x, b_x, s;
    logic [OUT_WIDTH-1:0] s_ext, acc_q, acc_base, acc_sum, acc_next, result;
    logic               ovf_evt;

    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no latches.
        a_x      = (WIDTH+1)'(sext_to(SEXT_MAX'(a_q), WIDTH));
        b_x      = (WIDTH+1)'(sext_to(SEXT_MAX'(b_q), WIDTH));
        s        = (ctrl_q.addsub == ADDSUB_ADD) ? a_x + b_x : a_x - b_x;
        s_ext    = OUT_WIDTH'(sext_to(SEXT_MAX'(s), WIDTH + 1));
        acc_base = ctrl_q.acc_clr ? '0 : acc_q;
        acc_sum  = acc_base + s_ext;
        ovf_evt  = ctrl_q.acc_mode && (acc_base[MSB] == s_ext[MSB])
                                   && (acc_sum[MSB] != acc_base[MSB]);
`ifdef ALU_ADDSUB_PIPE_SAT_EN
        acc_next = ovf_evt ? (s_ext[MSB] ? SAT_NEG : SAT_POS) : acc_sum;
`else
        acc_next = acc_sum;
`endif
        result   = ctrl_q.acc_mode ? acc_next : s_ext;
    end

    logic [OUT_WIDTH-1:0] res_q;
    logic                 res_valid_q;

    // Stage 2: the accumulator lives here, so back-to-back samples chain hazard-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            ovf         <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else if (ce) begin
            res_valid_q <= ctrl_q.valid;
            if (ctrl_q.valid) res_q <= result;
            if (ctrl_q.acc_mode)     acc_q <= acc_next;
            else if (ctrl_q.acc_clr) acc_q <= '0;
            ovf <= (ovf & ~ctrl_q.acc_clr) | ovf_evt;
        end
    end

    alu_pipe_dly #(
        .DEPTH (PIPE_STAGES - 2),
        .WIDTH (OUT_WIDTH)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (res_valid_q),
        .in_data   (res_q),
        .out_valid (out_valid),
        .out_data  (c)
    );

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Scoreboard bench for alu_addsub_pipe: a default instance plus an OUT_WIDTH=37
// instance for accumulator overflow (expectations follow ALU_ADDSUB_PIPE_SAT_EN).
module tb_alu_addsub_pipe;

    localparam int W   = 36;
    localparam int OW  = 55;
    localparam int OW1 = 37;
    localparam logic [W-1:0] M1 = 36'hFFFFFFFFF;
    localparam logic [W-1:0] PM = 36'h7FFFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] c;
        logic        ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic rst, ce;
    logic in_valid, addsub, acc_mode, acc_clr;
    logic [W-1:0] a, b;
    logic [OW-1:0] c;
    logic out_valid, ovf;

    logic in_valid1, addsub1, acc_mode1, acc_clr1;
    logic [W-1:0] a1, b1;
    logic [OW1-1:0] c1;
    logic out_valid1, ovf1;

    alu_addsub_pipe #(.WIDTH(W), .OUT_WIDTH(OW), .PIPE_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .addsub(addsub), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .c(c), .out_valid(out_valid), .ovf(ovf)
    );

    alu_addsub_pipe #(.WIDTH(W), .OUT_WIDTH(OW1), .PIPE_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid1), .a(a1), .b(b1),
        .addsub(addsub1), .acc_mode(acc_mode1), .acc_clr(acc_clr1),
        .c(c1), .out_valid(out_valid1), .ovf(ovf1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [OW-1:0] cv, input logic ov);
        exp_t e;
        e.c = 64'(cv);
        e.ovf = ov;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [OW1-1:0] cv, input logic ov);
        exp_t e;
        e.c = 64'(cv);
        e.ovf = ov;
        q1.push_back(e);
    endtask

    task automatic drive0(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic as, input logic am, input logic ac);
        @(negedge clk);
        in_valid = v; a = ia; b = ib; addsub = as; acc_mode = am; acc_clr = ac;
        in_valid1 = 1'b0; acc_clr1 = 1'b0;
    endtask

    task automatic drive1(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic as, input logic am, input logic ac);
        @(negedge clk);
        in_valid1 = v; a1 = ia; b1 = ib; addsub1 = as; acc_mode1 = am; acc_clr1 = ac;
        in_valid = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; acc_clr = 1'b0; in_valid1 = 1'b0; acc_clr1 = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_c"},     64'(c),         64'd0);
        check({tag, "_ovf"},   64'(ovf),       64'd0);
    endtask

    // Monitors: an output is consumed on an edge where ce=1 and out_valid=1.
    initial begin : mon0
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ce && out_valid) begin
                if (q0.size() == 0) begin
                    check("d0_unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = q0.pop_front();
                    check("d0_c", 64'(c), e.c);
                    check("d0_ovf", 64'(ovf), 64'(e.ovf));
                end
            end
        end
    end

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ce && out_valid1) begin
                if (q1.size() == 0) begin
                    check("d1_unexpected_out", 64'(out_valid1), 64'd0);
                end else begin
                    e = q1.pop_front();
                    check("d1_c", 64'(c1), e.c);
                    check("d1_ovf", 64'(ovf1), 64'(e.ovf));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1; ce = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; addsub = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; addsub1 = 1'b0; acc_mode1 = 1'b0; acc_clr1 = 1'b0;

        // Reset with random valid traffic.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = W'({$urandom, $urandom});
            b = W'({$urandom, $urandom});
            addsub = 1'($urandom); acc_mode = 1'($urandom); acc_clr = 1'($urandom);
            check_zero("rst");
            check("rst_d1_valid", 64'(out_valid1), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; acc_clr = 1'b0;
        idle(2);

        // Basic add with exact latency.
        drive0(1'b1, 36'd1, 36'd2, 1'b1, 1'b0, 1'b0);
        push0(55'd3, 1'b0);
        idle(1);
        check("add_lat1", 64'(out_valid), 64'd0);
        idle(1);
        check("add_lat2_valid", 64'(out_valid), 64'd1);
        check("add_lat2_c", 64'(c), 64'd3);
        idle(1);
        check("add_single", 64'(out_valid), 64'd0);
        check("add_c_hold", 64'(c), 64'd3);

        // Stall while the sample sits in stage 1.
        drive0(1'b1, 36'd2, 36'd3, 1'b1, 1'b0, 1'b0);
        push0(55'd5, 1'b0);
        idle(1);
        ce = 1'b0;
        check("stall_lat1", 64'(out_valid), 64'd0);
        idle(1);
        ce = 1'b1;
        check("stall_frozen", 64'(out_valid), 64'd0);
        idle(1);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_c", 64'(c), 64'd5);
        idle(1);
        check("stall_no_dup", 64'(out_valid), 64'd0);

        // Stall while the output is valid: held, consumed once.
        drive0(1'b1, 36'd10, 36'd3, 1'b0, 1'b0, 1'b0);
        push0(55'd7, 1'b0);
        idle(2);
        ce = 1'b0;
        check("hold_valid", 64'(out_valid), 64'd1);
        idle(1);
        ce = 1'b1;
        check("hold_repeat", 64'(out_valid), 64'd1);
        check("hold_c", 64'(c), 64'd7);
        idle(1);
        check("hold_done", 64'(out_valid), 64'd0);

        // Sign extension and extremes.
        drive0(1'b1, M1, M1, 1'b1, 1'b0, 1'b0);           push0(55'h7FFFFFFFFFFFFE, 1'b0);
        drive0(1'b1, M1, M1, 1'b0, 1'b0, 1'b0);           push0(55'h0, 1'b0);
        drive0(1'b1, M1, 36'd1, 1'b0, 1'b0, 1'b0);        push0(55'h7FFFFFFFFFFFFE, 1'b0);
        drive0(1'b1, PM, PM, 1'b1, 1'b0, 1'b0);           push0(55'h00000FFFFFFFFE, 1'b0);
        drive0(1'b1, 36'h800000000, PM, 1'b0, 1'b0, 1'b0); push0(55'h7FFFF000000001, 1'b0);
        idle(3);

        // Accumulate: load then three decrements, back to back.
        drive0(1'b1, 36'd4, 36'd1, 1'b1, 1'b1, 1'b1);     push0(55'd5, 1'b0);
        drive0(1'b1, M1, 36'd0, 1'b1, 1'b1, 1'b0);        push0(55'd4, 1'b0);
        drive0(1'b1, M1, 36'd0, 1'b1, 1'b1, 1'b0);        push0(55'd3, 1'b0);
        drive0(1'b1, M1, 36'd0, 1'b1, 1'b1, 1'b0);        push0(55'd2, 1'b0);
        // Lone clear, then accumulate from zero.
        drive0(1'b0, 36'd0, 36'd0, 1'b1, 1'b0, 1'b1);
        drive0(1'b1, 36'd7, 36'd0, 1'b1, 1'b1, 1'b0);     push0(55'd7, 1'b0);
        idle(3);

        // Reset mid-operation discards the in-flight sample and the accumulator.
        drive0(1'b1, 36'd5, 36'd5, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        check("midrst_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        idle(2);
        check("midrst_no_out", 64'(out_valid), 64'd0);
        drive0(1'b1, 36'd1, 36'd0, 1'b1, 1'b1, 1'b0);     push0(55'd1, 1'b0);
        idle(3);

        // Reset asserted during a ce=0 stall.
        drive0(1'b1, 36'd1, 36'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ce = 1'b0; rst = 1'b1; in_valid = 1'b1;
            a = W'({$urandom, $urandom}); b = W'({$urandom, $urandom});
            if (i > 0) check_zero("stallrst");
        end
        @(negedge clk);
        check_zero("stallrst_end");
        rst = 1'b0; ce = 1'b1; in_valid = 1'b0;
        idle(3);
        check("stallrst_no_out", 64'(out_valid), 64'd0);

        // Overflow on the 37-bit accumulator.
        drive1(1'b1, PM, PM, 1'b1, 1'b1, 1'b1);           push1(37'h0FFFFFFFFE, 1'b0);
`ifdef ALU_ADDSUB_PIPE_SAT_EN
        drive1(1'b1, PM, PM, 1'b1, 1'b1, 1'b0);           push1(37'h0FFFFFFFFF, 1'b1);
        drive1(1'b1, PM, PM, 1'b1, 1'b1, 1'b0);           push1(37'h0FFFFFFFFF, 1'b1);
`else
        drive1(1'b1, PM, PM, 1'b1, 1'b1, 1'b0);           push1(37'h1FFFFFFFFC, 1'b1);
        drive1(1'b1, PM, PM, 1'b1, 1'b1, 1'b0);           push1(37'h0FFFFFFFFA, 1'b1);
`endif
        drive1(1'b1, 36'd1, 36'd0, 1'b1, 1'b1, 1'b1);     push1(37'd1, 1'b0);
        drive1(1'b1, PM, PM, 1'b1, 1'b0, 1'b0);           push1(37'h0FFFFFFFFE, 1'b0);
        drive1(1'b1, PM, PM, 1'b1, 1'b1, 1'b1);           push1(37'h0FFFFFFFFE, 1'b0);
`ifdef ALU_ADDSUB_PIPE_SAT_EN
        drive1(1'b1, PM, PM, 1'b1, 1'b1, 1'b0);           push1(37'h0FFFFFFFFF, 1'b1);
`else
        drive1(1'b1, PM, PM, 1'b1, 1'b1, 1'b0);           push1(37'h1FFFFFFFFC, 1'b1);
`endif
        // Lone clear drops the sticky flag.
        drive1(1'b0, 36'd0, 36'd0, 1'b1, 1'b0, 1'b1);
        drive1(1'b1, 36'd1, 36'd1, 1'b1, 1'b0, 1'b0);     push1(37'd2, 1'b0);
        idle(1);

        // Drain both scoreboards within a bounded number of cycles.
        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
        check("drain_q0", 64'(q0.size()), 64'd0);
        check("drain_q1", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
- Parametrised, pipelined signed add/subtract unit with a valid qualifier, clock-enable stall and an optional running-accumulate mode.
- Successor to the fixed 36-in/55-out add/sub wrapper.
- Sits in the datapath between sample-formatting stages and downstream scaling/accumulation logic.

Parameters:
- WIDTH, 36, input operand width; two's-complement signed.
- OUT_WIDTH, 55, result/accumulator width; must be ≥ WIDTH+1.
- PIPE_STAGES, 2, input-to-output latency in enabled cycles; legal range 2..6.

Ports:
- clk  in  1  datapath clock.
- rst  in  1  reset; synchronous, active-high.
- ce  in  1  clock enable; 0 freezes the entire pipeline.
- in_valid  in  1  qualifies a, b, addsub, acc_mode and acc_clr.
- a  in  WIDTH  operand A, signed.
- b  in  WIDTH  operand B, signed.
- addsub  in  1  1 = a+b, 0 = a−b.
- acc_mode  in  1  1 = accumulate (a±b) into the accumulator.
- acc_clr  in  1  zero the accumulator; may accompany a sample.
- c  out  OUT_WIDTH  signed result.
- out_valid  out  1  c is valid this cycle.
- ovf  out  1  sticky accumulator overflow (or saturation) flag.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of ce):
  - c=0, out_valid=0, ovf=0, accumulator=0.
  - All in-flight valids are cleared.
  - Reset mid-operation discards every in-flight sample.
- Stage 1 registers a, b and the control bits together with in_valid. Control inputs are ignored when in_valid=0, except acc_clr.
- Stage 2 computes s = sext(a) ± sext(b) at WIDTH+1 bits; this is exact, with no overflow possible.
  - acc_mode=0: result = sext(s) to OUT_WIDTH. The accumulator is unchanged.
  - acc_mode=1: acc_next = acc + sext(s), wrapping at OUT_WIDTH bits; result = acc_next.
  - acc_clr with a valid sample: the accumulator is zeroed before the add (acc_next = sext(s)), i.e. a load.
  - acc_clr with no valid sample: the accumulator is set to 0 at stage 2 and no output is produced.
- Overflow: ovf is set when the accumulate add overflows (operand signs are equal and the result sign differs). It stays set until rst, or until stage 2 processes acc_clr.
- Stages 3..PIPE_STAGES are pure delay registers carrying the result and its valid bit.
- Latency: the sample presented at edge N appears on c/out_valid after PIPE_STAGES enabled edges.
- ce=0:
  - Every register holds, including the accumulator and ovf.
  - No bubbles are inserted and no samples are lost.
  - out_valid keeps its current value, so a held valid output is repeated. Consumers must gate with ce.
- Throughput is one sample per enabled cycle. Back-to-back accumulate samples chain correctly with no hazard, because the accumulator lives in stage 2.
- c holds its last value when out_valid=0. It is not zeroed.

Optional Feature:
- Macro: ALU_ADDSUB_PIPE_SAT_EN.
- Defined: an accumulate overflow clamps acc_next to +max (0 followed by all ones) or −max (1 followed by all zeros), according to the operand sign. ovf is set on the same event.
- Undefined: wrap-around two's-complement accumulation, with ovf detected as above.
- Non-accumulate results are unaffected in both builds.

Decomposition:
- Package alu_pkg:
  - ADDSUB_ADD=1'b1 and ADDSUB_SUB=1'b0 constants.
  - A typedef for the stage-1 control bundle {valid, addsub, acc_mode, acc_clr}.
  - Helper function sext_to for sign extension to a target width.
- Sub-module alu_pipe_dly: parametrised depth/width delay line with ce and sync reset. It is used for stages 3..PIPE_STAGES; depth 0 is a pass-through.

Test Plan (WIDTH=36, OUT_WIDTH=55, PIPE_STAGES=2 unless noted):
- Reset: rst=1 for 10 cycles with random inputs and in_valid=1 -> c=0, out_valid=0, ovf=0 throughout. Same result when rst is asserted during a ce=0 stall.
- Basic add: a=1, b=2, addsub=1, in_valid=1 for one cycle -> out_valid=1 exactly 2 cycles later with c=3.
- Stall: a=2, b=3 valid, then ce=0 for 1 cycle -> c=5 appears one cycle later than without the stall. No duplicate result while ce=1.
- Sign extension: a=b=36'hFFFFFFFFF, add -> c=55'h7FFFFFFFFFFFFE (−2). Same operands with sub -> c=0. a=36'hFFFFFFFFF, b=1, sub -> c=−2.
- Accumulate: acc_clr=1 with a=4, b=1, add, then three samples a=−1, b=0 -> c=5, 4, 3, 2 on consecutive cycles. A lone acc_clr followed by a=7, b=0 -> c=7.
- Overflow (OUT_WIDTH=37): repeatedly accumulate a=36'h7FFFFFFFF, b=36'h7FFFFFFFF.
  - 2nd sum wraps negative and ovf=1.
  - With ALU_ADDSUB_PIPE_SAT_EN, c sticks at 37'h0FFFFFFFFF and ovf=1.
  - acc_clr clears ovf.
